// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and defaults for the pipeline hazard / forwarding controller.
//   fwd_sel_e    : operand source select (register file, WB stage, MEM stage)
//   stage_ctrl_t : per-stage shadow control bits that qualify a register write
//   writes_reg() : "this stage writes register r" predicate, with optional
//                  hardwired-zero register suppression
// No ports (package).
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int XLEN_DEF = 64;
    localparam int NREG_DEF = 32;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    // Control half of a shadow stage; register indices are kept beside it
    // because their width depends on the instantiating module's NREG.
    typedef struct packed {
        logic valid;
        logic regwrite;
    } stage_ctrl_t;

    // wr_en   : stage valid & regwrite
    // match   : stage rd equals the register being asked about
    // is_zero : the register being asked about is index 0
    function automatic logic writes_reg(input logic wr_en, input logic match,
                                        input logic is_zero, input bit zero_reg);
        return wr_en & match & ~(zero_reg & is_zero);
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_fwd_mux.sv
// -----------------------------------------------------------------------------
// fwd_mux
// Per-operand priority compare and 3:1 operand select.
// MEM has priority over WB; a MEM-stage load is never a forwarding source
// because its data does not exist yet (the load-use stall covers that case).
// With USE_MEM = 0 the MEM leg is disabled, giving the WB-only write-through
// variant used for the ID operands.
// Ports:
//   src         : source register index being read
//   rf_data     : value read without forwarding
//   mem_wr      : MEM stage valid & regwrite
//   mem_memread : MEM stage holds a load
//   mem_rd      : MEM stage destination index
//   mem_data    : MEM stage ALU result
//   wb_wr       : WB stage valid & regwrite
//   wb_rd       : WB stage destination index
//   wb_data     : value written back this cycle
//   sel         : chosen source (fwd_sel_e)
//   op          : selected operand value
// -----------------------------------------------------------------------------
module fwd_mux
    import hazard_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int AW       = 5,
    parameter bit ZERO_REG = 1'b1,
    parameter bit USE_MEM  = 1'b1
) (
    input  logic [AW-1:0]   src,
    input  logic [XLEN-1:0] rf_data,
    input  logic            mem_wr,
    input  logic            mem_memread,
    input  logic [AW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_wr,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output fwd_sel_e        sel,
    output logic [XLEN-1:0] op
);

    logic src_zero;
    logic mem_hit;
    logic wb_hit;

    assign src_zero = (src == '0);

    always_comb begin
        mem_hit = USE_MEM & ~mem_memread &
                  writes_reg(mem_wr, mem_rd == src, src_zero, ZERO_REG);
        wb_hit  = writes_reg(wb_wr, wb_rd == src, src_zero, ZERO_REG);
        sel     = FWD_RF;
        op      = rf_data;
        if (mem_hit) begin
            sel = FWD_MEM;
            op  = mem_data;
        end else if (wb_hit) begin
            sel = FWD_WB;
            op  = wb_data;
        end
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// hazard_fwd_unit
// Hazard and forwarding controller for a 5-stage IF/ID/EX/MEM/WB core.
// Keeps a shadow pipeline (EX, MEM, WB) of destination/control info and from
// it produces forwarded EX operands, write-through ID operands, one-cycle
// load-use stalls and IF/ID + ID/EX squashes on taken branches.
// Optional build macro: HAZARD_PERF_EN adds saturating 32-bit event counters
// perf_stall_cnt / perf_flush_cnt / perf_fwd_cnt.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   id_valid                   : ID holds a real instruction
//   id_rs1/id_rs2              : ID source indices
//   id_uses_rs1/id_uses_rs2    : instruction really reads rs1/rs2
//   id_rd, id_regwrite, id_memread : ID destination and control
//   id_rs1data/id_rs2data      : register file read data
//   ex_rs1data/ex_rs2data      : ID/EX latched operand data
//   ex_branch_taken            : branch in EX resolved taken
//   mem_alures                 : EX/MEM ALU result
//   wb_data                    : write-back value this cycle
//   stall                      : hold PC and IF/ID
//   bubble_idex                : load NOP controls into ID/EX
//   flush_ifid                 : clear IF/ID
//   fwd_a_sel/fwd_b_sel        : 00 regfile, 01 WB, 10 MEM
//   ex_op_a/ex_op_b            : forwarded EX operands
//   id_op_a/id_op_b            : write-through ID operands
// -----------------------------------------------------------------------------
module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int   XLEN     = XLEN_DEF,
    parameter int   NREG     = NREG_DEF,
    parameter bit   ZERO_REG = 1'b1,
    localparam int  AW       = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs1,
    input  logic [AW-1:0]   id_rs2,
    input  logic            id_uses_rs1,
    input  logic            id_uses_rs2,
    input  logic [AW-1:0]   id_rd,
    input  logic            id_regwrite,
    input  logic            id_memread,
    input  logic [XLEN-1:0] id_rs1data,
    input  logic [XLEN-1:0] id_rs2data,
    input  logic [XLEN-1:0] ex_rs1data,
    input  logic [XLEN-1:0] ex_rs2data,
    input  logic            ex_branch_taken,
    input  logic [XLEN-1:0] mem_alures,
    input  logic [XLEN-1:0] wb_data,
`ifdef HAZARD_PERF_EN
    output logic [31:0]     perf_stall_cnt,
    output logic [31:0]     perf_flush_cnt,
    output logic [31:0]     perf_fwd_cnt,
`endif
    output logic            stall,
    output logic            bubble_idex,
    output logic            flush_ifid,
    output logic [1:0]      fwd_a_sel,
    output logic [1:0]      fwd_b_sel,
    output logic [XLEN-1:0] ex_op_a,
    output logic [XLEN-1:0] ex_op_b,
    output logic [XLEN-1:0] id_op_a,
    output logic [XLEN-1:0] id_op_b
);

    // Shadow pipeline
    stage_ctrl_t   ex_ctrl, mem_ctrl, wb_ctrl;
    logic          ex_memread, mem_memread;
    logic [AW-1:0] ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ctrl     <= '0;
            mem_ctrl    <= '0;
            wb_ctrl     <= '0;
            ex_memread  <= 1'b0;
            mem_memread <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
            mem_rd      <= '0;
            wb_rd       <= '0;
        end else begin
            wb_ctrl     <= mem_ctrl;
            wb_rd       <= mem_rd;
            mem_ctrl    <= ex_ctrl;
            mem_rd      <= ex_rd;
            mem_memread <= ex_memread;
            if (bubble_idex) begin
                ex_ctrl    <= '0;
                ex_memread <= 1'b0;
                ex_rs1     <= '0;
                ex_rs2     <= '0;
                ex_rd      <= '0;
            end else begin
                ex_ctrl.valid    <= id_valid;
                ex_ctrl.regwrite <= id_regwrite;
                ex_memread       <= id_memread;
                ex_rs1           <= id_rs1;
                ex_rs2           <= id_rs2;
                ex_rd            <= id_rd;
            end
        end
    end

    // Load-use detection: a load in EX whose destination is read by ID.
    logic ex_load_writes;
    logic load_use;

    assign ex_load_writes = ex_memread &
                            writes_reg(ex_ctrl.valid & ex_ctrl.regwrite, 1'b1,
                                       ex_rd == '0, ZERO_REG);
    assign load_use = id_valid & ex_load_writes &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) |
                       (id_uses_rs2 & (id_rs2 == ex_rd)));

    // A taken branch squashes the ID instruction anyway, so it overrides the
    // stall. The flush is masked during reset so every control output drops
    // the moment reset is asserted.
    assign flush_ifid  = ex_branch_taken & ~reset;
    assign stall       = load_use & ~ex_branch_taken;
    assign bubble_idex = stall | flush_ifid;

    logic mem_wr, wb_wr;
    assign mem_wr = mem_ctrl.valid & mem_ctrl.regwrite;
    assign wb_wr  = wb_ctrl.valid & wb_ctrl.regwrite;

    fwd_sel_e sel_a, sel_b, id_sel_a_unused, id_sel_b_unused;

    fwd_mux #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .USE_MEM(1'b1)) u_fwd_ex_a (
        .src(ex_rs1), .rf_data(ex_rs1data),
        .mem_wr(mem_wr), .mem_memread(mem_memread), .mem_rd(mem_rd), .mem_data(mem_alures),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .sel(sel_a), .op(ex_op_a)
    );

    fwd_mux #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .USE_MEM(1'b1)) u_fwd_ex_b (
        .src(ex_rs2), .rf_data(ex_rs2data),
        .mem_wr(mem_wr), .mem_memread(mem_memread), .mem_rd(mem_rd), .mem_data(mem_alures),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .sel(sel_b), .op(ex_op_b)
    );

    // ID write-through covers the register file's same-edge read-before-write.
    fwd_mux #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .USE_MEM(1'b0)) u_fwd_id_a (
        .src(id_rs1), .rf_data(id_rs1data),
        .mem_wr(1'b0), .mem_memread(1'b0), .mem_rd('0), .mem_data('0),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .sel(id_sel_a_unused), .op(id_op_a)
    );

    fwd_mux #(.XLEN(XLEN), .AW(AW), .ZERO_REG(ZERO_REG), .USE_MEM(1'b0)) u_fwd_id_b (
        .src(id_rs2), .rf_data(id_rs2data),
        .mem_wr(1'b0), .mem_memread(1'b0), .mem_rd('0), .mem_data('0),
        .wb_wr(wb_wr), .wb_rd(wb_rd), .wb_data(wb_data),
        .sel(id_sel_b_unused), .op(id_op_b)
    );

    assign fwd_a_sel = sel_a;
    assign fwd_b_sel = sel_b;

`ifdef HAZARD_PERF_EN
    logic any_fwd;
    assign any_fwd = (sel_a != FWD_RF) | (sel_b != FWD_RF);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
            perf_fwd_cnt   <= '0;
        end else begin
            if (stall && perf_stall_cnt != 32'hFFFF_FFFF)
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush_ifid && perf_flush_cnt != 32'hFFFF_FFFF)
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            if (any_fwd && perf_fwd_cnt != 32'hFFFF_FFFF)
                perf_fwd_cnt <= perf_fwd_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_fwd_unit
// Bench for hazard_fwd_unit (default build, XLEN=64, NREG=32, ZERO_REG=1).
// The reference keeps a three-entry history of the instructions that entered
// EX (newest first) and derives every output from the hazard/forwarding rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hazard_fwd_unit;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [63:0] id_rs1data, id_rs2data, ex_rs1data, ex_rs2data, mem_alures, wb_data;
    logic        ex_branch_taken;
    logic        stall, bubble_idex, flush_ifid;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [63:0] ex_op_a, ex_op_b, id_op_a, id_op_b;

    hazard_fwd_unit #(.XLEN(64), .NREG(32), .ZERO_REG(1'b1)) dut (
        .clk(clk), .reset(reset),
        .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .id_rs1data(id_rs1data), .id_rs2data(id_rs2data),
        .ex_rs1data(ex_rs1data), .ex_rs2data(ex_rs2data),
        .ex_branch_taken(ex_branch_taken), .mem_alures(mem_alures), .wb_data(wb_data),
        .stall(stall), .bubble_idex(bubble_idex), .flush_ifid(flush_ifid),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .id_op_a(id_op_a), .id_op_b(id_op_b)
    );

    // ---------------- reference model ----------------
    typedef struct {
        bit       valid;
        bit [4:0] rs1, rs2, rd;
        bit       regwrite, memread;
    } ins_t;

    ins_t hist[$];   // hist[0] = in EX, hist[1] = in MEM, hist[2] = in WB

    bit          m_stall, m_bubble, m_flush;
    bit [1:0]    m_sel_a, m_sel_b;
    logic [63:0] m_ex_a, m_ex_b, m_id_a, m_id_b;

    function automatic bit wr(ins_t s, bit [4:0] r);
        return s.valid && s.regwrite && (s.rd == r) && (r != 5'd0);
    endfunction

    function automatic void model_reset();
        ins_t z;
        z = '{default: 0};
        hist.delete();
        repeat (3) hist.push_back(z);
    endfunction

    function automatic void ex_operand(input bit [4:0] src, input logic [63:0] rf,
                                       output bit [1:0] sel, output logic [63:0] val);
        if (wr(hist[1], src) && !hist[1].memread) begin
            sel = 2'd2; val = mem_alures;
        end else if (wr(hist[2], src)) begin
            sel = 2'd1; val = wb_data;
        end else begin
            sel = 2'd0; val = rf;
        end
    endfunction

    function automatic void compute_exp();
        ins_t e;
        bit   lu;
        e = hist[0];
        m_flush = ex_branch_taken && !reset;
        lu = id_valid && e.memread && wr(e, e.rd) &&
             ((id_uses_rs1 && id_rs1 == e.rd) || (id_uses_rs2 && id_rs2 == e.rd));
        m_stall  = lu && !ex_branch_taken;
        m_bubble = m_stall || m_flush;
        ex_operand(e.rs1, ex_rs1data, m_sel_a, m_ex_a);
        ex_operand(e.rs2, ex_rs2data, m_sel_b, m_ex_b);
        m_id_a = wr(hist[2], id_rs1) ? wb_data : id_rs1data;
        m_id_b = wr(hist[2], id_rs2) ? wb_data : id_rs2data;
    endfunction

    function automatic void model_advance();
        ins_t n;
        compute_exp();
        if (m_bubble) begin
            n = '{default: 0};
        end else begin
            n.valid = id_valid; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
            n.regwrite = id_regwrite; n.memread = id_memread;
        end
        hist.push_front(n);
        void'(hist.pop_back());
    endfunction

    // ---------------- scoreboard ----------------
    logic [262:0] exp_q[$];
    int n_vec  = 0;
    int n_miss = 0;

    task automatic cmp(input string nm, input logic [63:0] got, input logic [63:0] want);
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic pin(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        cmp(nm, got, want);
    endtask

    task automatic do_check(input string nm);
        logic [262:0] ev;
        #1;
        compute_exp();
        exp_q.push_back({m_stall, m_bubble, m_flush, m_sel_a, m_sel_b,
                         m_ex_a, m_ex_b, m_id_a, m_id_b});
        ev = exp_q.pop_front();
        n_vec++;
        cmp({nm, "/stall"},       {63'd0, stall},       {63'd0, ev[262]});
        cmp({nm, "/bubble_idex"}, {63'd0, bubble_idex}, {63'd0, ev[261]});
        cmp({nm, "/flush_ifid"},  {63'd0, flush_ifid},  {63'd0, ev[260]});
        cmp({nm, "/fwd_a_sel"},   {62'd0, fwd_a_sel},   {62'd0, ev[259:258]});
        cmp({nm, "/fwd_b_sel"},   {62'd0, fwd_b_sel},   {62'd0, ev[257:256]});
        cmp({nm, "/ex_op_a"},     ex_op_a,              ev[255:192]);
        cmp({nm, "/ex_op_b"},     ex_op_b,              ev[191:128]);
        cmp({nm, "/id_op_a"},     id_op_a,              ev[127:64]);
        cmp({nm, "/id_op_b"},     id_op_b,              ev[63:0]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_advance();
        #1;
    endtask

    task automatic rand_data();
        id_rs1data = {$urandom, $urandom};
        id_rs2data = {$urandom, $urandom};
        ex_rs1data = {$urandom, $urandom};
        ex_rs2data = {$urandom, $urandom};
        mem_alures = {$urandom, $urandom};
        wb_data    = {$urandom, $urandom};
        ex_branch_taken = 1'b0;
    endtask

    task automatic set_id(input bit v, input bit [4:0] rs1, input bit [4:0] rs2,
                          input bit u1, input bit u2, input bit [4:0] rd,
                          input bit rw, input bit mr);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
        id_rd = rd; id_regwrite = rw; id_memread = mr;
    endtask

    task automatic clr_id();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        clr_id();
        rand_data();
        model_reset();
        #2;
        do_check("reset");
        pin("reset/stall", {63'd0, stall}, 64'd0);
        pin("reset/fwd_a_sel", {62'd0, fwd_a_sel}, 64'd0);
        pin("reset/ex_op_a", ex_op_a, ex_rs1data);
        #7 reset = 1'b0;

        // MEM -> EX forward
        tick(); rand_data(); set_id(1, 1, 2, 1, 1, 5, 1, 0); do_check("t1a");
        tick(); rand_data(); set_id(1, 5, 1, 1, 1, 6, 1, 0); do_check("t1b");
        tick(); rand_data(); clr_id(); mem_alures = 64'h2A; do_check("t1c");
        pin("t1/fwd_a_sel", {62'd0, fwd_a_sel}, 64'd2);
        pin("t1/ex_op_a", ex_op_a, 64'h2A);
        pin("t1/stall", {63'd0, stall}, 64'd0);
        pin("t1/model_sel_a", {62'd0, m_sel_a}, 64'd2);

        // load-use stall, then WB forward
        tick(); rand_data(); set_id(1, 1, 2, 1, 0, 7, 1, 1); do_check("t2a");
        tick(); rand_data(); set_id(1, 7, 2, 1, 1, 8, 1, 0); do_check("t2b");
        pin("t2/stall", {63'd0, stall}, 64'd1);
        pin("t2/bubble_idex", {63'd0, bubble_idex}, 64'd1);
        pin("t2/model_stall", {63'd0, m_stall}, 64'd1);
        tick(); rand_data(); do_check("t2c");
        pin("t2/stall_one_cycle", {63'd0, stall}, 64'd0);
        tick(); rand_data(); clr_id(); wb_data = 64'h1234; do_check("t2d");
        pin("t2/fwd_a_sel", {62'd0, fwd_a_sel}, 64'd1);
        pin("t2/ex_op_a", ex_op_a, 64'h1234);

        // MEM beats WB
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 9, 1, 0); do_check("t3a");
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 9, 1, 0); do_check("t3b");
        tick(); rand_data(); set_id(1, 9, 1, 1, 1, 10, 1, 0); do_check("t3c");
        tick(); rand_data(); clr_id(); mem_alures = 64'h11; wb_data = 64'h22; do_check("t3d");
        pin("t3/fwd_a_sel", {62'd0, fwd_a_sel}, 64'd2);
        pin("t3/ex_op_a", ex_op_a, 64'h11);

        // x0 is never hazarded or forwarded
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 0, 1, 0); do_check("t4a");
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 0, 1, 1); do_check("t4b");
        tick(); rand_data(); set_id(1, 0, 0, 1, 1, 1, 1, 0); do_check("t4c");
        pin("t4/stall", {63'd0, stall}, 64'd0);
        tick(); rand_data(); clr_id(); do_check("t4d");
        pin("t4/fwd_a_sel", {62'd0, fwd_a_sel}, 64'd0);
        pin("t4/fwd_b_sel", {62'd0, fwd_b_sel}, 64'd0);
        pin("t4/ex_op_a", ex_op_a, ex_rs1data);

        // branch flush beats load-use
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 7, 1, 1); do_check("t5a");
        tick(); rand_data(); set_id(1, 7, 2, 1, 1, 8, 1, 0); ex_branch_taken = 1'b1; do_check("t5b");
        pin("t5/flush_ifid", {63'd0, flush_ifid}, 64'd1);
        pin("t5/stall", {63'd0, stall}, 64'd0);
        pin("t5/bubble_idex", {63'd0, bubble_idex}, 64'd1);
        tick(); rand_data(); set_id(1, 7, 2, 1, 1, 8, 1, 0); do_check("t5c");
        pin("t5/model_ex_valid", {63'd0, hist[0].valid}, 64'd0);
        pin("t5/stall_after", {63'd0, stall}, 64'd0);

        // ID write-through
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 3, 1, 0); do_check("t6a");
        tick(); rand_data(); clr_id(); do_check("t6b");
        tick(); rand_data(); clr_id(); do_check("t6c");
        tick(); rand_data(); set_id(1, 3, 2, 1, 1, 4, 1, 0);
        id_rs1data = 64'h3; wb_data = 64'h55; do_check("t6d");
        pin("t6/id_op_a", id_op_a, 64'h55);

        // asynchronous reset in the middle of a stall / flush
        tick(); rand_data(); set_id(1, 1, 2, 0, 0, 7, 1, 1); do_check("t7a");
        tick(); rand_data(); set_id(1, 7, 2, 1, 1, 8, 1, 0); do_check("t7b");
        pin("t7/stall_pre", {63'd0, stall}, 64'd1);
        ex_branch_taken = 1'b1;
        reset = 1'b1;
        model_reset();
        do_check("t7c");
        pin("t7/stall", {63'd0, stall}, 64'd0);
        pin("t7/bubble_idex", {63'd0, bubble_idex}, 64'd0);
        pin("t7/flush_ifid", {63'd0, flush_ifid}, 64'd0);
        #2 reset = 1'b0;
        ex_branch_taken = 1'b0;

        // randomized traffic on a small register window to provoke hazards
        for (int i = 0; i < 600; i++) begin
            tick();
            rand_data();
            begin
                bit rw, mr;
                rw = ($urandom_range(0, 3) != 0);
                mr = rw && ($urandom_range(0, 2) == 0);
                set_id($urandom_range(0, 9) < 8,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
                       5'($urandom_range(0, 7)), rw, mr);
            end
            ex_branch_taken = ($urandom_range(0, 9) == 0);
            do_check("rand");
            if (i % 97 == 50) begin
                reset = 1'b1;
                model_reset();
                do_check("rand_reset");
                #1 reset = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
Parametrised hazard and forwarding controller for the 5-stage pipelined core (IF/ID/EX/MEM/WB). It keeps its own shadow pipeline of destination and control info for the EX, MEM and WB stages. From this it produces:
- forwarded EX operands
- write-through ID operands
- one-cycle load-use stalls
- flushes on taken branches resolved in EX

It sits beside the ID/EX pipeline register and feeds the ALU operand inputs and the PC/IF-ID enables.

Parameters:
XLEN, 64, datapath/operand width in bits
NREG, 32, architectural register count; AW = $clog2(NREG) is a derived localparam
ZERO_REG, 1, 1 = register 0 is hardwired zero and never forwarded or hazarded

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1, id_rs2  in  AW  ID source register indices
id_uses_rs1, id_uses_rs2  in  1  instruction actually reads rs1/rs2
id_rd  in  AW  ID destination index
id_regwrite, id_memread  in  1  ID control bits
id_rs1data, id_rs2data  in  XLEN  register file read data
ex_rs1data, ex_rs2data  in  XLEN  ID/EX latched operand data
ex_branch_taken  in  1  branch in EX resolved taken
mem_alures  in  XLEN  EX/MEM ALU result
wb_data  in  XLEN  value being written back this cycle
stall  out  1  hold PC and IF/ID
bubble_idex  out  1  load NOP controls into ID/EX
flush_ifid  out  1  clear IF/ID
fwd_a_sel, fwd_b_sel  out  2  00 = regfile, 01 = WB, 10 = MEM
ex_op_a, ex_op_b  out  XLEN  forwarded EX operands
id_op_a, id_op_b  out  XLEN  write-through ID operands

Behaviour:
- Shadow stages: EX{valid, rs1, rs2, rd, regwrite, memread}, MEM{valid, rd, regwrite, memread}, WB{valid, rd, regwrite}.
- Reset clears every shadow field asynchronously to 0. After reset:
  - stall = bubble_idex = flush_ifid = 0
  - fwd_*_sel = 00
  - ex_op_* = ex_rs*data; id_op_* = id_rs*data
- Each posedge, not in reset:
  - WB <= MEM; MEM <= EX.
  - EX <= bubble (all zero) if flush_ifid or stall, else ID inputs with valid = id_valid.
- A stage "writes r" when valid & regwrite & rd == r & !(ZERO_REG & r == 0).
- Load-use stall (combinational):
  - Condition: stall = id_valid & EX.memread & EX writes rd & ((id_uses_rs1 & id_rs1 == EX.rd) | (id_uses_rs2 & id_rs2 == EX.rd)).
  - Asserted for exactly one cycle. Next cycle the load is in MEM, the shadow EX holds a bubble, and the operand is forwarded from WB one cycle later.
  - bubble_idex = stall | flush_ifid.
- Flush: flush_ifid = ex_branch_taken. It has priority over stall, so stall is forced to 0 when ex_branch_taken = 1. This gives two squashed instructions (IF/ID and ID/EX).
- EX forwarding for operand A (B is symmetric with rs2):
  - MEM writes EX.rs1 & !MEM.memread -> sel 10, mem_alures.
  - Else WB writes EX.rs1 -> sel 01, wb_data.
  - Else sel 00, ex_rs1data. MEM has priority over WB.
  - MEM write with MEM.memread set is never forwarded; the stall prevents it from being needed.
- ID write-through: WB writes id_rs1 -> id_op_a = wb_data, else id_rs1data. Same for B. This removes the same-edge read-before-write hazard in the register file.
- All outputs are combinational from the shadow regs and inputs; no added latency.
- Reset mid-stall or mid-flush: shadow is cleared and all control outputs drop to 0 immediately (asynchronous).

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt, perf_flush_cnt, perf_fwd_cnt, each 32 bits.
  - Counters count cycles with stall=1, with flush_ifid=1, and with any fwd_*_sel != 00.
  - Saturate at 32'hFFFF_FFFF; cleared by reset.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package hazard_pkg:
  - fwd_sel_e enum {FWD_RF = 2'b00, FWD_WB = 2'b01, FWD_MEM = 2'b10}
  - shadow-stage struct typedef
  - default XLEN/NREG constants
- One natural sub-module, fwd_mux: per-operand priority compare and 3:1 select. Instantiated twice for EX and twice (WB-only variant) for ID.

Test Plan:
- add x5 in EX, then add x6,x5,x1 enters EX next cycle (MEM.rd = 5, mem_alures = 0x2A) -> fwd_a_sel = 10, ex_op_a = 0x2A, no stall.
- ld x7 in EX, dependent add x8,x7,x2 in ID -> stall = 1 and bubble_idex = 1 for one cycle. Two cycles later fwd_a_sel = 01 and ex_op_a = wb_data (0x1234).
- Both MEM and WB write x9 (0x11 / 0x22) while the EX reads x9 -> MEM wins, ex_op_a = 0x11.
- Writes targeting x0 with ZERO_REG = 1 -> no stall, sel 00.
- ex_branch_taken = 1 coincident with a load-use condition -> flush_ifid = 1, stall = 0. Next cycle the shadow EX valid = 0.
- WB writes x3 = 0x55 while ID reads x3 (id_rs1data stale = 0x3) -> id_op_a = 0x55. Separately, asserting reset mid-stall clears all outputs within the same cycle.
